mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
- Shares one WIDTH-bit 2:1 select datapath between two requesters (A = sel 0, B = sel 1).
- Arbitrates with round-robin and a bounded burst, drives the mux select, and registers the winning word into one output slot.
- The output slot uses a valid/ready handshake toward the downstream consumer.
- Sits in front of any 5-bit consumer that previously had a hard-wired select.

Parameters:
- WIDTH, 5, data width of each requester and of the output.
- BURST_MAX, 4, max consecutive grants to one requester while the other is requesting; 1 gives pure round-robin. Legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_a  in  1  requester A has a word; held until gnt_a
- data_a  in  WIDTH  requester A word; stable while req_a is high
- gnt_a  out  1  A's word accepted this cycle (combinational)
- req_b  in  1  requester B has a word
- data_b  in  WIDTH  requester B word
- gnt_b  out  1  B's word accepted this cycle (combinational)
- sel  out  1  current select driven to the mux: 0 = A, 1 = B (combinational)
- out_valid  out  1  output slot holds a word
- out_data  out  WIDTH  registered winning word
- out_ready  in  1  consumer accepts out_data this cycle

Behaviour:
- Reset values (asynchronous, immediate):
  - out_valid = 0, out_data = 0.
  - last_sel = 0, burst_cnt = 0.
  - gnt_a and gnt_b are forced to 0 while rst_n is low.
- Slot FSM (2 states):
  - EMPTY (out_valid = 0): slot is free.
  - FULL (out_valid = 1): slot is free only in a cycle where out_ready = 1.
- Accept condition: accept = slot_free & (req_a | req_b). At most one gnt is high per cycle, and only when accept is true.
- Pick rules:
  - Only A requesting: pick A. Only B requesting: pick B.
  - Both requesting: pick last_sel if burst_cnt < BURST_MAX, else pick ~last_sel.
- sel rules:
  - sel = the pick when any request is present.
  - Otherwise sel = last_sel, so the select does not toggle when idle.
- On an accept edge:
  - out_data <= chosen data (through the 2:1 select) and out_valid <= 1.
  - If pick == last_sel: burst_cnt <= min(burst_cnt + 1, BURST_MAX). Otherwise burst_cnt <= 1 and last_sel <= pick.
- FULL & out_ready & no request: out_valid <= 0.
- FULL & out_ready & accept: the slot is replaced in the same cycle, giving full throughput of 1 word per cycle.
- FULL & !out_ready: hold out_data and out_valid. No gnt; requesters stall.
- Latency: 1 cycle from gnt to out_valid. A word is never dropped or duplicated.
- First contention after reset grants A (last_sel = 0, burst_cnt = 0 < BURST_MAX).
- The fairness bound is exact: with both continuously requesting, the grant pattern is BURST_MAX grants to one requester, then BURST_MAX to the other.
- Reset mid-operation: a pending out_data is discarded. Requesters must re-present their words; no gnt is issued while in reset.

Decomposition:
- Shared package:
  - WIDTH default.
  - Select encodings SEL_A = 1'b0, SEL_B = 1'b1.
  - EMPTY/FULL state encoding.
- One natural sub-module: rr_pick2 (combinational pick from req_a, req_b, last_sel, burst_cnt; produces pick and any_req).
- The 2:1 datapath select is the team's existing 5-bit mux2, instantiated with sel.

Test Plan:
- Reset and idle: assert rst_n = 0 mid-stream with out_valid = 1. Required: out_valid = 0, out_data = 0 and gnts = 0 asynchronously; no grant while held in reset.
- Single requester: req_a = 1, data_a = 5'h0A, out_ready = 1. Required: gnt_a = 1 that cycle, sel = 0; next cycle out_valid = 1, out_data = 5'h0A.
- Contention, BURST_MAX = 4: both requesting continuously, out_ready = 1, data_a = 5'h01, data_b = 5'h1F. Required output sequence A,A,A,A,B,B,B,B,A…; sel toggles every 4 accepts.
- Backpressure: out_valid = 1, out_ready = 0 for 3 cycles with both requesting. Required: out_data stable, gnt_a = gnt_b = 0; then out_ready = 1 produces one gnt in the same cycle and new data on the next edge.
- BURST_MAX = 1 with A alone for 3 words, then B joins. Required: A,A,A, then strict alternation B,A,B; burst_cnt saturates and never exceeds 1.
- Requester withdraw: B requests once during an A burst of burst_cnt = 2. Required: A keeps the grant until burst_cnt = BURST_MAX, then B is granted exactly once; afterwards A alone gets burst_cnt = 1.

Source files
------------

// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin arbiter in front of
// the 5-bit mux2 datapath.
package mux2_rr_arbiter_pkg;

  localparam int WIDTH_DEF     = 5;
  localparam int BURST_MAX_DEF = 4;

  // Burst counter width; holds any legal BURST_MAX (1..15).
  localparam int CNT_W = 4;

  // Mux select encodings.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Output slot occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Request/grant and output handshake bundle for mux2_rr_arbiter.
// The requesters and the downstream consumer sit on the master side.
interface mux2_rr_arbiter_if
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             req_a;
  logic [WIDTH-1:0] data_a;
  logic             gnt_a;
  logic             req_b;
  logic [WIDTH-1:0] data_b;
  logic             gnt_b;
  logic             sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
    output req_a, data_a, req_b, data_b, out_ready,
    input  gnt_a, gnt_b, sel, out_valid, out_data
  );

  modport slave (
    input  req_a, data_a, req_b, data_b, out_ready,
    output gnt_a, gnt_b, sel, out_valid, out_data
  );

endinterface

// File: rtl/mux2.sv
// Plain WIDTH-bit 2:1 select: sel = 0 passes d0, sel = 1 passes d1.
module mux2 #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux2_rr_arbiter_rr_pick2.sv
// Combinational round-robin pick between two requesters with a bounded
// burst: the last winner keeps the grant until it has won BURST_MAX in a row.
module rr_pick2
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic             req_a,
  input  logic             req_b,
  input  logic             last_sel,
  input  logic [CNT_W-1:0] burst_cnt,
  output logic             pick,
  output logic             any_req
);

  // Decide which requester wins this cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    pick    = last_sel;
    any_req = req_a | req_b;
    if (req_a && !req_b) begin
      pick = SEL_A;
    end else if (!req_a && req_b) begin
      pick = SEL_B;
    end else if (req_a && req_b) begin
      pick = (burst_cnt < CNT_W'(BURST_MAX)) ? last_sel : ~last_sel;
    end
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 select between requesters A and B,
// registering the winning word into a single valid/ready output slot.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  mux2_rr_arbiter_if.slave  bus
);

  slot_state_t      state;
  logic             last_sel;
  logic [CNT_W-1:0] burst_cnt;
  logic [WIDTH-1:0] out_data_q;
  logic             pick;
  logic             any_req;
  logic             slot_free;
  logic             accept;
  logic [WIDTH-1:0] mux_y;

  rr_pick2 #(
    .BURST_MAX (BURST_MAX)
  ) u_pick (
    .req_a     (bus.req_a),
    .req_b     (bus.req_b),
    .last_sel  (last_sel),
    .burst_cnt (burst_cnt),
    .pick      (pick),
    .any_req   (any_req)
  );

  mux2 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .d0  (bus.data_a),
    .d1  (bus.data_b),
    .sel (bus.sel),
    .y   (mux_y)
  );

  // The slot can take a word when empty or when it is being drained now;
  // grants are suppressed while reset is held.
  assign slot_free     = (state == EMPTY) | bus.out_ready;
  assign accept        = rst_n & slot_free & any_req;
  assign bus.gnt_a     = accept & (pick == SEL_A);
  assign bus.gnt_b     = accept & (pick == SEL_B);
  assign bus.sel       = any_req ? pick : last_sel;
  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = out_data_q;

  // Slot FSM plus round-robin history: load on accept, drain on ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      out_data_q <= '0;
      last_sel   <= SEL_A;
      burst_cnt  <= '0;
    end else if (accept) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state      <= FULL;
      out_data_q <= mux_y;
      if (pick == last_sel) begin
        if (burst_cnt < CNT_W'(BURST_MAX)) begin
          burst_cnt <= burst_cnt + CNT_W'(1);
        end
      end else begin
        burst_cnt <= CNT_W'(1);
        last_sel  <= pick;
      end
    end else if (state == FULL && bus.out_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench: two arbiters (BURST_MAX = 4 and 1) compared every
// cycle against a run-length model, plus directed literal expectations.
module tb_mux2_rr_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mux2_rr_arbiter_if #(.WIDTH(5)) bus4 ();
  mux2_rr_arbiter_if #(.WIDTH(5)) bus1 ();

  mux2_rr_arbiter #(.WIDTH(5), .BURST_MAX(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  mux2_rr_arbiter #(.WIDTH(5), .BURST_MAX(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: last winner, how many times in a row it has won, and the slot.
  logic       m_valid [2];
  logic [4:0] m_data  [2];
  logic       m_last  [2];
  int         m_run   [2];
  int         bm      [2] = '{4, 1};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_data[i]  = 5'h00;
      m_last[i]  = 1'b0;
      m_run[i]   = 0;
    end
  endtask

  task automatic model_step(input int i, input logic ra, input logic rb,
                            input logic [4:0] da, input logic [4:0] db,
                            input logic ordy, input logic ga, input logic gb,
                            input logic sl, input logic ov, input logic [4:0] od);
    string tag;
    logic  any_r, pk, acc;
    tag   = (i == 0) ? "bm4" : "bm1";
    any_r = ra | rb;
    if (ra && rb) pk = (m_run[i] < bm[i]) ? m_last[i] : ~m_last[i];
    else          pk = rb;
    acc = (!m_valid[i] || ordy) && any_r;
    check({tag, ".out_valid"}, 32'(ov), 32'(m_valid[i]));
    check({tag, ".out_data"},  32'(od), 32'(m_data[i]));
    check({tag, ".gnt_a"},     32'(ga), 32'(acc && !pk));
    check({tag, ".gnt_b"},     32'(gb), 32'(acc && pk));
    check({tag, ".sel"},       32'(sl), 32'(any_r ? pk : m_last[i]));
    if (acc) begin
      m_valid[i] = 1'b1;
      m_data[i]  = pk ? db : da;
      if (pk == m_last[i]) m_run[i] = m_run[i] + 1;
      else begin
        m_run[i]  = 1;
        m_last[i] = pk;
      end
    end else if (m_valid[i] && ordy) begin
      m_valid[i] = 1'b0;
    end
  endtask

  // Compare process: mid-cycle, inputs settled, against the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst.bm4_gnt", 32'({bus4.gnt_a, bus4.gnt_b}), 32'h0);
      check("rst.bm1_gnt", 32'({bus1.gnt_a, bus1.gnt_b}), 32'h0);
      check("rst.bm4_valid", 32'(bus4.out_valid), 32'h0);
      check("rst.bm4_data", 32'(bus4.out_data), 32'h0);
      model_reset();
    end else begin
      model_step(0, bus4.req_a, bus4.req_b, bus4.data_a, bus4.data_b, bus4.out_ready,
                 bus4.gnt_a, bus4.gnt_b, bus4.sel, bus4.out_valid, bus4.out_data);
      model_step(1, bus1.req_a, bus1.req_b, bus1.data_a, bus1.data_b, bus1.out_ready,
                 bus1.gnt_a, bus1.gnt_b, bus1.sel, bus1.out_valid, bus1.out_data);
    end
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [8:0] seq_b, seq_sel;
  logic [4:0] held;
  logic [3:0] wd_a, wd_b;
  logic [5:0] b1_a, b1_b;

  initial begin
    bus4.req_a = 0; bus4.req_b = 0; bus4.data_a = 0; bus4.data_b = 0; bus4.out_ready = 0;
    bus1.req_a = 0; bus1.req_b = 0; bus1.data_a = 0; bus1.data_b = 0; bus1.out_ready = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    bus4.req_a = 1'b1;
    #2;
    check("init_rst_gnt_a", 32'(bus4.gnt_a), 32'h0);
    check("init_rst_valid", 32'(bus4.out_valid), 32'h0);
    repeat (2) cyc();
    check("init_rst_hold_gnt", 32'(bus4.gnt_a), 32'h0);
    bus4.req_a = 1'b0;
    rst_n = 1'b1;

    // Single requester.
    bus4.req_a = 1'b1; bus4.data_a = 5'h0A; bus4.out_ready = 1'b1;
    #2;
    check("single_gnt_a", 32'(bus4.gnt_a), 32'h1);
    check("single_sel", 32'(bus4.sel), 32'h0);
    cyc();
    bus4.req_a = 1'b0; bus4.out_ready = 1'b0;
    #2;
    check("single_valid", 32'(bus4.out_valid), 32'h1);
    check("single_data", 32'(bus4.out_data), 32'h0A);

    // Asynchronous reset with a word pending.
    bus4.req_a = 1'b1; bus4.data_a = 5'h11;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(bus4.out_valid), 32'h0);
    check("midrst_data", 32'(bus4.out_data), 32'h0);
    check("midrst_gnt_a", 32'(bus4.gnt_a), 32'h0);
    repeat (2) begin
      cyc();
      #2;
      check("midrst_hold_gnt", 32'({bus4.gnt_a, bus4.gnt_b}), 32'h0);
    end
    cyc();
    rst_n = 1'b1;

    // Contention, BURST_MAX = 4.
    bus4.req_a = 1'b1; bus4.req_b = 1'b1;
    bus4.data_a = 5'h01; bus4.data_b = 5'h1F; bus4.out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      #2;
      seq_sel[k] = bus4.sel;
      cyc();
      seq_b[k] = (bus4.out_data == 5'h1F);
    end
    check("contention_words_b", 32'(seq_b), 32'h0F0);
    check("contention_sel", 32'(seq_sel), 32'h0F0);
    check("contention_last_data", 32'(bus4.out_data), 32'h01);

    // Backpressure with both requesting.
    bus4.out_ready = 1'b0;
    held = bus4.out_data;
    for (int k = 0; k < 3; k++) begin
      #2;
      check("bp_no_gnt", 32'({bus4.gnt_a, bus4.gnt_b}), 32'h0);
      check("bp_data_stable", 32'(bus4.out_data), 32'(held));
      check("bp_valid", 32'(bus4.out_valid), 32'h1);
      cyc();
    end
    bus4.out_ready = 1'b1;
    #2;
    check("bp_release_gnt", 32'({bus4.gnt_a, bus4.gnt_b}), 32'h2);
    cyc();
    check("bp_release_valid", 32'(bus4.out_valid), 32'h1);

    // Withdraw: B asks once while A sits at burst 2.
    for (int k = 0; k < 4; k++) begin
      #2;
      wd_a[k] = bus4.gnt_a;
      wd_b[k] = bus4.gnt_b;
      cyc();
      if (wd_b[k]) bus4.req_b = 1'b0;
    end
    check("withdraw_gnt_a", 32'(wd_a), 32'hB);
    check("withdraw_gnt_b", 32'(wd_b), 32'h4);
    check("withdraw_last_data", 32'(bus4.out_data), 32'h01);
    bus4.req_a = 1'b0;

    // BURST_MAX = 1: A alone three times, then B joins.
    bus1.req_a = 1'b1; bus1.data_a = 5'h03; bus1.data_b = 5'h1C; bus1.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 3) bus1.req_b = 1'b1;
      #2;
      b1_a[k] = bus1.gnt_a;
      b1_b[k] = bus1.gnt_b;
      cyc();
    end
    check("bm1_gnt_a", 32'(b1_a), 32'h17);
    check("bm1_gnt_b", 32'(b1_b), 32'h28);
    check("bm1_last_data", 32'(bus1.out_data), 32'h1C);
    bus1.req_a = 1'b0; bus1.req_b = 1'b0;

    repeat (3) cyc();
    #2;
    check("drain_valid4", 32'(bus4.out_valid), 32'h0);
    check("drain_valid1", 32'(bus1.out_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
